alarm_ringer: RTL and testbench

ALARM_RINGER -- requirements
Module: alarm_ringer

---
 rtl/alarm_ringer_if.sv | 23 ++
 rtl/alarm_ringer.sv | 131 +++++++++++++
 tb/tb_alarm_ringer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/alarm_ringer_if.sv
// Signal bundle between the alarm ringer and its surroundings: control inputs in,
// piezo drive and status out.
interface alarm_ringer_if;
  logic       tick1s;
  logic       alarmStatus;
  logic       alarmRing;
  logic       snoozeBtn;
  logic       dismissBtn;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic [2:0] snoozeCount;

  modport master (
    output tick1s, alarmStatus, alarmRing, snoozeBtn, dismissBtn,
    input  buzzer, ringing, snoozing, snoozeCount
  );

  modport slave (
    input  tick1s, alarmStatus, alarmRing, snoozeBtn, dismissBtn,
    output buzzer, ringing, snoozing, snoozeCount
  );
endinterface

// File: rtl/alarm_ringer.sv
// Alarm ringer: rings on an alarm-time match, supports a limited number of
// snoozes, a dismiss, and an automatic timeout, with a 1 s on / 1 s off beep.
module alarm_ringer #(
  parameter int unsigned RING_TIMEOUT_SEC = 60,
  parameter int unsigned SNOOZE_SEC       = 300,
  parameter int unsigned MAX_SNOOZE       = 3
) (
  input  logic           uclock,
  input  logic           rst_n,
  alarm_ringer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE, DONE} state_t;

  localparam logic [15:0] RING_LAST   = 16'(RING_TIMEOUT_SEC - 1);
  localparam logic [15:0] SNOOZE_LAST = 16'(SNOOZE_SEC - 1);
  localparam logic [2:0]  SNOOZE_MAX  = 3'(MAX_SNOOZE);

  state_t      state, stateNext;
  logic [15:0] secCnt, secCntNext;
  logic        beepPhase, beepNext;
  logic [2:0]  snoozeCount, snoozeCountNext;
  logic        ringQ, snoozeQ, dismissQ;
  logic        buzzerQ, ringingQ, snoozingQ;
  logic        ringEdge, snoozeEdge, dismissEdge;

  assign ringEdge    = bus.alarmRing  & ~ringQ;
  assign snoozeEdge  = bus.snoozeBtn  & ~snoozeQ;
  assign dismissEdge = bus.dismissBtn & ~dismissQ;

  always_comb begin
    stateNext       = state;
    secCntNext      = secCnt;
    beepNext        = beepPhase;
    snoozeCountNext = snoozeCount;

    if (!bus.alarmStatus) begin
      stateNext       = IDLE;
      secCntNext      = '0;
      beepNext        = 1'b0;
      snoozeCountNext = '0;
    end else begin
      unique case (state)
        IDLE: begin
          snoozeCountNext = '0;
          if (ringEdge) begin
            stateNext  = RING;
            secCntNext = '0;
            beepNext   = 1'b1;
          end
        end

        // A snooze edge at the limit falls through, so a same-cycle tick still counts.
        RING: begin
          if (dismissEdge) begin
            stateNext = DONE;
          end else if (snoozeEdge && (snoozeCount < SNOOZE_MAX)) begin
            stateNext       = SNOOZE;
            snoozeCountNext = snoozeCount + 3'd1;
            secCntNext      = '0;
            beepNext        = 1'b0;
          end else if (bus.tick1s) begin
            if (secCnt == RING_LAST) begin
              stateNext = DONE;
            end else begin
              secCntNext = secCnt + 16'd1;
              beepNext   = ~beepPhase;
            end
          end
        end

        SNOOZE: begin
          if (dismissEdge) begin
            stateNext = DONE;
          end else if (bus.tick1s) begin
            if (secCnt == SNOOZE_LAST) begin
              stateNext  = RING;
              secCntNext = '0;
              beepNext   = 1'b1;
            end else begin
              secCntNext = secCnt + 16'd1;
            end
          end
        end

        DONE: begin
          if (!bus.alarmRing) begin
            stateNext       = IDLE;
            secCntNext      = '0;
            beepNext        = 1'b0;
            snoozeCountNext = '0;
          end
        end

        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge uclock) begin
    if (!rst_n) begin
      state       <= IDLE;
      secCnt      <= '0;
      beepPhase   <= 1'b0;
      snoozeCount <= '0;
      ringQ       <= 1'b0;
      snoozeQ     <= 1'b0;
      dismissQ    <= 1'b0;
      buzzerQ     <= 1'b0;
      ringingQ    <= 1'b0;
      snoozingQ   <= 1'b0;
    end else begin
      state       <= stateNext;
      secCnt      <= secCntNext;
      beepPhase   <= beepNext;
      snoozeCount <= snoozeCountNext;
      ringQ       <= bus.alarmRing;
      snoozeQ     <= bus.snoozeBtn;
      dismissQ    <= bus.dismissBtn;
      buzzerQ     <= (stateNext == RING) && beepNext;
      ringingQ    <= (stateNext == RING);
      snoozingQ   <= (stateNext == SNOOZE);
    end
  end

  assign bus.buzzer      = buzzerQ;
  assign bus.ringing     = ringingQ;
  assign bus.snoozing    = snoozingQ;
  assign bus.snoozeCount = snoozeCount;

endmodule

// File: tb/tb_alarm_ringer.sv
// Scoreboard bench for alarm_ringer: the driver queues hand-computed outputs per
// cycle, the monitor compares them on the falling edge after they take effect.
module tb_alarm_ringer;

  logic uclock = 1'b0;
  logic rst_n  = 1'b0;
  always #5 uclock = ~uclock;

  alarm_ringer_if bus ();

  alarm_ringer #(
    .RING_TIMEOUT_SEC (4),
    .SNOOZE_SEC       (3),
    .MAX_SNOOZE       (2)
  ) dut (
    .uclock (uclock),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  typedef struct {
    int unsigned cyc;
    string       name;
    logic [5:0]  exp;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc      = 0;
  int unsigned checks   = 0;
  int unsigned failures = 0;

  always @(posedge uclock) cyc <= cyc + 1;

  // Expected vector layout: {ringing, snoozing, buzzer, snoozeCount[2:0]}
  always @(negedge uclock) begin
    exp_t       e;
    logic [5:0] act;
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      e   = q.pop_front();
      act = {bus.ringing, bus.snoozing, bus.buzzer, bus.snoozeCount};
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s: ring/snz/buz/cnt got %b_%b_%b_%0d required %b_%b_%b_%0d",
                 e.name, act[5], act[4], act[3], act[2:0],
                 e.exp[5], e.exp[4], e.exp[3], e.exp[2:0]);
      end
    end
  end

  function automatic logic [5:0] ex(input bit r, input bit s, input bit b, input int c);
    return {r, s, b, 3'(c)};
  endfunction

  task automatic step(input logic tk, input string nm, input logic [5:0] e);
    bus.tick1s = tk;
    q.push_back('{cyc: cyc + 1, name: nm, exp: e});
    @(posedge uclock);
    #1;
    bus.tick1s = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tick1s      = 1'b0;
    bus.alarmStatus = 1'b0;
    bus.alarmRing   = 1'b0;
    bus.snoozeBtn   = 1'b0;
    bus.dismissBtn  = 1'b0;
    #1;

    // Reset state
    step(0, "reset0", ex(0,0,0,0));
    step(0, "reset1", ex(0,0,0,0));

    // Basic ring, beep cadence and timeout
    rst_n = 1'b1; bus.alarmStatus = 1'b1;
    step(0, "idle", ex(0,0,0,0));
    bus.alarmRing = 1'b1;
    step(0, "ringStart", ex(1,0,1,0));
    step(1, "ringTick1", ex(1,0,0,0));
    step(1, "ringTick2", ex(1,0,1,0));
    step(0, "ringHold", ex(1,0,1,0));
    step(1, "ringTick3", ex(1,0,0,0));
    step(1, "ringTimeout", ex(0,0,0,0));
    step(1, "doneHold", ex(0,0,0,0));
    bus.alarmRing = 1'b0;
    step(0, "doneToIdle", ex(0,0,0,0));

    // Snooze, snooze expiry, snooze limit, dismiss
    bus.alarmRing = 1'b1;
    step(0, "ring2", ex(1,0,1,0));
    bus.snoozeBtn = 1'b1;
    step(0, "snooze1", ex(0,1,0,1));
    step(1, "snz1Tick1", ex(0,1,0,1));
    bus.snoozeBtn = 1'b0;
    step(1, "snz1Tick2", ex(0,1,0,1));
    bus.snoozeBtn = 1'b1;
    step(0, "snzEdgeIgnored", ex(0,1,0,1));
    bus.snoozeBtn = 1'b0;
    step(1, "snz1Expire", ex(1,0,1,1));
    bus.snoozeBtn = 1'b1;
    step(0, "snooze2", ex(0,1,0,2));
    bus.snoozeBtn = 1'b0;
    step(1, "snz2Tick1", ex(0,1,0,2));
    step(1, "snz2Tick2", ex(0,1,0,2));
    step(1, "snz2Expire", ex(1,0,1,2));
    bus.snoozeBtn = 1'b1;
    step(0, "snoozeAtLimit", ex(1,0,1,2));
    bus.snoozeBtn = 1'b0;
    step(0, "ringAfterLimit", ex(1,0,1,2));
    bus.dismissBtn = 1'b1;
    step(0, "dismiss", ex(0,0,0,2));
    bus.dismissBtn = 1'b0;
    step(0, "doneKeepsCount", ex(0,0,0,2));
    bus.alarmRing = 1'b0;
    step(0, "idleClearsCount", ex(0,0,0,0));

    // Snooze and dismiss together (plus tick) resolve to dismiss
    bus.alarmRing = 1'b1;
    step(0, "ring3", ex(1,0,1,0));
    bus.snoozeBtn = 1'b1;
    step(0, "snooze3", ex(0,1,0,1));
    bus.snoozeBtn = 1'b0;
    step(1, "snz3Tick1", ex(0,1,0,1));
    step(1, "snz3Tick2", ex(0,1,0,1));
    step(1, "snz3Expire", ex(1,0,1,1));
    bus.snoozeBtn = 1'b1; bus.dismissBtn = 1'b1;
    step(1, "snoozeAndDismiss", ex(0,0,0,1));
    bus.snoozeBtn = 1'b0; bus.dismissBtn = 1'b0; bus.alarmRing = 1'b0;
    step(0, "idle3", ex(0,0,0,0));

    // Disarm during snooze; disarmed edges ignored; armed with level high is no edge
    bus.alarmRing = 1'b1;
    step(0, "ring4", ex(1,0,1,0));
    bus.snoozeBtn = 1'b1;
    step(0, "snooze4", ex(0,1,0,1));
    bus.snoozeBtn = 1'b0; bus.alarmStatus = 1'b0;
    step(1, "disarmInSnooze", ex(0,0,0,0));
    bus.alarmRing = 1'b0;
    step(0, "disarmedIdle", ex(0,0,0,0));
    bus.alarmRing = 1'b1;
    step(0, "disarmedEdge", ex(0,0,0,0));
    bus.alarmStatus = 1'b1;
    step(0, "armedNoEdge", ex(0,0,0,0));
    bus.alarmRing = 1'b0;
    step(0, "idle4", ex(0,0,0,0));

    // Reset mid-ring; release with alarmRing high rings; held level gives no second ring
    bus.alarmRing = 1'b1;
    step(0, "ring5", ex(1,0,1,0));
    step(1, "ring5Tick", ex(1,0,0,0));
    rst_n = 1'b0;
    step(0, "resetMidRing", ex(0,0,0,0));
    step(0, "resetHold", ex(0,0,0,0));
    rst_n = 1'b1;
    step(0, "ringAfterReset", ex(1,0,1,0));
    bus.dismissBtn = 1'b1;
    step(0, "dismiss5", ex(0,0,0,0));
    bus.dismissBtn = 1'b0;
    step(1, "noRetrig1", ex(0,0,0,0));
    step(1, "noRetrig2", ex(0,0,0,0));
    step(0, "noRetrig3", ex(0,0,0,0));
    bus.alarmRing = 1'b0;
    step(0, "idle5", ex(0,0,0,0));

    repeat (3) @(posedge uclock);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
